// File: rtl/alu_gen_pkg.sv
// alu_gen shared types: opcodes, FSM states
// and a small opcode legality helper.
package alu_gen_pkg;

  typedef enum logic [3:0] {
    OP_NOP = 4'd0,
    OP_ADD = 4'd1,
    OP_AND = 4'd2,
    OP_XOR = 4'd3,
    OP_MUL = 4'd4,
    OP_SUB = 4'd5,
    OP_SHL = 4'd6,
    OP_SHR = 4'd7
  } operation_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    MUL  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Opcodes 8..15 are reserved and raise err.
  function automatic logic op_legal(
    input logic [3:0] op
  );
    return !op[3];
  endfunction

endpackage

// File: rtl/alu_gen_if.sv
// alu_gen request/response bundle.
// master = requester, slave = alu core.
interface alu_gen_if #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 5
);
  logic                 start;
  logic [3:0]           op;
  logic [WIDTH-1:0]     A;
  logic [WIDTH-1:0]     B;
  logic [ADDR_W-1:0]    wr_addr;
  logic [ADDR_W-1:0]    rd_addr;
  logic                 done;
  logic                 busy;
  logic                 err;
  logic [2*WIDTH-1:0]   result;
  logic [2*WIDTH-1:0]   rd_data;

  modport master (
    output start, op, A, B,
    output wr_addr, rd_addr,
    input  done, busy, err,
    input  result, rd_data
  );

  modport slave (
    input  start, op, A, B,
    input  wr_addr, rd_addr,
    output done, busy, err,
    output result, rd_data
  );
endinterface

// File: rtl/alu_gen_mul.sv
// Iterative unsigned shift-add multiplier,
// one partial product per step.
module alu_gen_mul #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] product
);
  localparam int RW = 2 * WIDTH;

  logic [RW-1:0]    acc;
  logic [RW-1:0]    mcand;
  logic [WIDTH-1:0] mplier;

  // product already includes the step in
  // progress, so the last step's value can
  // be captured on the same edge.
  always_comb begin
    product = acc;
    if (mplier[0])
      product = acc + mcand;
  end

  // Accumulator, shifted multiplicand and
  // consumed multiplier bits.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (load) begin
      acc    <= '0;
      mcand  <= RW'(a);
      mplier <= b;
    end else if (step) begin
      acc    <= product;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end
endmodule

// File: rtl/alu_gen_core.sv
// alu_gen core: 4-state sequencer, datapath,
// result memory with read-first port.
module alu_gen_core
  import alu_gen_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 32
) (
  input logic       clk,
  input logic       reset_n,
  alu_gen_if.slave  bus
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int RW     = 2 * WIDTH;
  localparam int SH_W   = $clog2(RW);
  localparam int CW     = $clog2(WIDTH);

  state_t state;
  state_t state_nxt;

  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;
  logic [3:0]        op_q;
  logic [ADDR_W-1:0] wa_q;
  logic [CW-1:0]     cnt;
  logic [RW-1:0]     result_q;
  logic [RW-1:0]     rd_q;
  logic              err_q;
  logic [RW-1:0]     mem [DEPTH];

  logic          accept;
  logic          mul_load;
  logic          mul_step;
  logic          fin;
  logic          legal;
  logic [RW-1:0] exec_res;
  logic [RW-1:0] product;

  alu_gen_mul #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (mul_load),
    .step    (mul_step),
    .a       (bus.A),
    .b       (bus.B),
    .product (product)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Next state and control strobes.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    mul_load  = 1'b0;
    mul_step  = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          accept = 1'b1;
          if (bus.op == OP_MUL) begin
            mul_load  = 1'b1;
            state_nxt = MUL;
          end else if (bus.op != OP_NOP) begin
            state_nxt = EXEC;
          end
        end
      end
      EXEC: state_nxt = DONE;
      MUL: begin
        mul_step = 1'b1;
        if (cnt == CW'(WIDTH - 1))
          state_nxt = DONE;
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign fin = (state_nxt == DONE);

  // Result of the latched operation.
  always_comb begin
    exec_res = '0;
    legal    = op_legal(op_q);
    case (op_q)
      OP_ADD: exec_res = RW'(a_q) + RW'(b_q);
      OP_AND: exec_res = RW'(a_q & b_q);
      OP_XOR: exec_res = RW'(a_q ^ b_q);
      OP_MUL: exec_res = product;
      OP_SUB: exec_res = RW'(a_q) - RW'(b_q);
      OP_SHL: exec_res = RW'(a_q) << b_q[SH_W-1:0];
      OP_SHR: exec_res = RW'(a_q) >> b_q[SH_W-1:0];
      default: exec_res = '0;
    endcase
  end

  // Operand latch, step counter, result,
  // error flag and result memory.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      wa_q     <= '0;
      cnt      <= '0;
      result_q <= '0;
      rd_q     <= '0;
      err_q    <= 1'b0;
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else begin
      rd_q <= mem[bus.rd_addr];
      if (accept) begin
        a_q   <= bus.A;
        b_q   <= bus.B;
        op_q  <= bus.op;
        wa_q  <= bus.wr_addr;
        cnt   <= '0;
        err_q <= 1'b0;
      end
      if (mul_step)
        cnt <= cnt + 1'b1;
      if (fin) begin
        result_q <= legal ? exec_res : '0;
        err_q    <= !legal;
        if (legal)
          mem[wa_q] <= exec_res;
      end
    end
  end

  assign bus.done    = (state == DONE);
  assign bus.busy    = (state != IDLE);
  assign bus.err     = err_q;
  assign bus.result  = result_q;
  assign bus.rd_data = rd_q;
endmodule

// File: tb/tb_alu_gen_core.sv
// Directed bench for alu_gen_core,
// WIDTH=8 DEPTH=32.
module tb_alu_gen_core;
  logic clk = 1'b0;
  logic reset_n = 1'b0;

  int n_vec  = 0;
  int n_miss = 0;
  int lat;

  alu_gen_if #(.WIDTH(8), .ADDR_W(5)) bus ();

  alu_gen_core #(
    .WIDTH (8),
    .DEPTH (32)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s got=%h exp=%h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request, hold start for the
  // accept edge only, wait for done.
  task automatic run_op(
    input  logic [3:0] o,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [4:0] wa,
    output int         n
  );
    bus.op      = o;
    bus.A       = a;
    bus.B       = b;
    bus.wr_addr = wa;
    bus.start   = 1'b1;
    tick();
    n = 1;
    bus.start = 1'b0;
    while (!bus.done && n < 50) begin
      tick();
      n++;
    end
  endtask

  initial begin
    bus.start   = 1'b0;
    bus.op      = 4'h0;
    bus.A       = 8'h00;
    bus.B       = 8'h00;
    bus.wr_addr = 5'd0;
    bus.rd_addr = 5'd0;
    reset_n     = 1'b0;
    tick();
    tick();
    check("rst_busy",   32'(bus.busy),    32'd0);
    check("rst_done",   32'(bus.done),    32'd0);
    check("rst_err",    32'(bus.err),     32'd0);
    check("rst_result", 32'(bus.result),  32'h0);
    check("rst_rddata", 32'(bus.rd_data), 32'h0);
    reset_n = 1'b1;
    tick();

    // add with carry, then read back
    run_op(4'h1, 8'hFF, 8'h01, 5'd3, lat);
    check("add_lat", 32'(lat),        32'd2);
    check("add_res", 32'(bus.result), 32'h0100);
    check("add_err", 32'(bus.err),    32'd0);
    tick();
    check("add_idle", 32'(bus.busy),  32'd0);
    bus.rd_addr = 5'd3;
    tick();
    check("add_mem", 32'(bus.rd_data), 32'h0100);

    // mul with an add request while busy
    bus.op      = 4'h4;
    bus.A       = 8'hFF;
    bus.B       = 8'hFF;
    bus.wr_addr = 5'd5;
    bus.start   = 1'b1;
    tick();
    lat = 1;
    bus.op = 4'h1;
    bus.A  = 8'h11;
    bus.B  = 8'h22;
    for (int i = 0; i < 4; i++) begin
      tick();
      lat++;
    end
    check("mul_busy", 32'(bus.busy), 32'd1);
    bus.start = 1'b0;
    while (!bus.done && lat < 50) begin
      tick();
      lat++;
    end
    check("mul_lat", 32'(lat),        32'd9);
    check("mul_res", 32'(bus.result), 32'hFE01);
    tick();
    check("mul_nodone", 32'(bus.done), 32'd0);
    check("mul_idle",   32'(bus.busy), 32'd0);
    bus.rd_addr = 5'd5;
    tick();
    check("mul_mem", 32'(bus.rd_data), 32'hFE01);

    // illegal opcode onto addr 3
    run_op(4'hF, 8'h12, 8'h34, 5'd3, lat);
    check("ill_lat", 32'(lat),        32'd2);
    check("ill_err", 32'(bus.err),    32'd1);
    check("ill_res", 32'(bus.result), 32'h0);
    bus.rd_addr = 5'd3;
    tick();
    tick();
    check("ill_mem", 32'(bus.rd_data), 32'h0100);

    run_op(4'h5, 8'h01, 8'h02, 5'd6, lat);
    check("sub_res", 32'(bus.result), 32'hFFFF);
    check("sub_err", 32'(bus.err),    32'd0);
    tick();
    run_op(4'h6, 8'h81, 8'h04, 5'd7, lat);
    check("shl_res", 32'(bus.result), 32'h0810);
    tick();
    run_op(4'h7, 8'h80, 8'h07, 5'd8, lat);
    check("shr_res", 32'(bus.result), 32'h0001);
    tick();
    run_op(4'h3, 8'hA5, 8'h0F, 5'd10, lat);
    check("xor_res", 32'(bus.result), 32'h00AA);
    tick();
    run_op(4'h2, 8'hA5, 8'h0F, 5'd11, lat);
    check("and_res", 32'(bus.result), 32'h0005);
    tick();

    // reset during the 4th MUL cycle
    bus.op      = 4'h4;
    bus.A       = 8'h0F;
    bus.B       = 8'h0F;
    bus.wr_addr = 5'd12;
    bus.start   = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 3; i++)
      tick();
    reset_n = 1'b0;
    tick();
    check("mrst_busy", 32'(bus.busy),   32'd0);
    check("mrst_done", 32'(bus.done),   32'd0);
    check("mrst_res",  32'(bus.result), 32'h0);
    reset_n     = 1'b1;
    bus.rd_addr = 5'd3;
    tick();
    check("mrst_mem3", 32'(bus.rd_data), 32'h0);
    bus.rd_addr = 5'd12;
    tick();
    check("mrst_mem12", 32'(bus.rd_data), 32'h0);
    for (int i = 0; i < 12; i++) begin
      tick();
      check("mrst_nodone", 32'(bus.done), 32'd0);
    end

    // add after reset, read-first on addr 9
    bus.rd_addr = 5'd9;
    run_op(4'h1, 8'h02, 8'h03, 5'd9, lat);
    check("add2_res", 32'(bus.result),  32'h0005);
    check("rd_first", 32'(bus.rd_data), 32'h0);
    tick();
    check("rd_new", 32'(bus.rd_data), 32'h0005);

    // no_op for one cycle
    bus.op    = 4'h0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("nop_busy", 32'(bus.busy), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("nop_done", 32'(bus.done), 32'd0);
      check("nop_busy2", 32'(bus.busy), 32'd0);
    end
    check("nop_res", 32'(bus.result), 32'h0005);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_miss);
    $finish;
  end
endmodule
